// File: rtl/retire_trace_pkg.sv
// rtl/retire_trace_pkg.sv - shared types and classifier for the retirement trace buffer
package retire_trace_pkg;

   localparam int DATA_W    = 16;
   localparam int REG_IDX_W = 3;
   localparam int CNT_W     = 32;

   typedef enum logic [2:0] {
      NOP   = 3'd0,
      REG   = 3'd1,
      LOAD  = 3'd2,
      STORE = 3'd3,
      STU   = 3'd4,
      HALT  = 3'd5
   } trc_kind_e;

   typedef struct packed {
      logic [CNT_W-1:0]     inum;
      trc_kind_e            kind;
      logic [DATA_W-1:0]    pc;
      logic [DATA_W-1:0]    inst;
      logic [REG_IDX_W-1:0] wreg;
      logic [DATA_W-1:0]    wdata;
      logic [DATA_W-1:0]    addr;
      logic [DATA_W-1:0]    mdata;
   } rec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } trc_state_e;

   // Register-writing kinds win over halt, halt wins over a plain store.
   function automatic trc_kind_e classify(input logic reg_write,
                                          input logic mem_read,
                                          input logic mem_write,
                                          input logic halt);
      trc_kind_e k;
      if (reg_write && mem_write)     k = STU;
      else if (reg_write && mem_read) k = LOAD;
      else if (reg_write)             k = REG;
      else if (halt)                  k = HALT;
      else if (mem_write)             k = STORE;
      else                            k = NOP;
      return k;
   endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// rtl/trace_sync_fifo.sv - first-word-fall-through synchronous FIFO with wrap-bit pointers
module trace_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr_q, wptr_d;
   logic [AW:0]  rptr_q, rptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   // Head is read straight from storage, so a write lands on dout_o the cycle after.
   assign dout_o  = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - retire record capture, classify, INUM stamp, FIFO and end-of-run FSM
// Optional: RETIRE_TRACE_SKIP_NOP_EN filters NOP records out of the FIFO.
module retire_trace_buffer
   import retire_trace_pkg::*;
#(
   parameter int DATA_W    = retire_trace_pkg::DATA_W,
   parameter int REG_IDX_W = retire_trace_pkg::REG_IDX_W,
   parameter int DEPTH     = 8,
   parameter int CNT_W     = retire_trace_pkg::CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ret_valid,
   input  logic [DATA_W-1:0]    ret_pc,
   input  logic [DATA_W-1:0]    ret_inst,
   input  logic                 ret_reg_write,
   input  logic [REG_IDX_W-1:0] ret_write_reg,
   input  logic [DATA_W-1:0]    ret_write_data,
   input  logic                 ret_mem_read,
   input  logic                 ret_mem_write,
   input  logic [DATA_W-1:0]    ret_mem_addr,
   input  logic [DATA_W-1:0]    ret_mem_data,
   input  logic                 ret_halt,
   output logic                 ret_stall,
   output logic                 trc_valid,
   input  logic                 trc_ready,
   output rec_t                 trc_record,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     inst_count,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 halted
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   trc_state_e       state_q, state_d;
   logic [CNT_W-1:0] inum_q, inum_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] inst_q, inst_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   trc_kind_e kind;
   rec_t      rec_in;
   logic      fifo_full, fifo_empty;
   logic      pop, push, drop, retire, in_run, nop_filtered, enq_try;

   assign kind = classify(ret_reg_write, ret_mem_read, ret_mem_write, ret_halt);

`ifdef RETIRE_TRACE_SKIP_NOP_EN
   assign nop_filtered = (kind == NOP);
`else
   assign nop_filtered = 1'b0;
`endif

   assign in_run    = (state_q == RUN);
   assign trc_valid = !fifo_empty;
   assign pop       = trc_valid && trc_ready;
   assign ret_stall = fifo_full && !pop;
   assign enq_try   = ret_valid && in_run && !nop_filtered;
   assign push      = enq_try && (!fifo_full || pop);
   assign drop      = enq_try && fifo_full && !pop;
   // Filtered NOPs still count as retired so the INUM gap shows them.
   assign retire    = push || (ret_valid && in_run && nop_filtered);

   always_comb begin
      rec_in       = '0;
      rec_in.inum  = inum_q;
      rec_in.kind  = kind;
      rec_in.pc    = ret_pc;
      rec_in.inst  = ret_inst;
      rec_in.wreg  = ret_write_reg;
      rec_in.wdata = ret_write_data;
      rec_in.addr  = ret_mem_addr;
      rec_in.mdata = ret_mem_data;
   end

   trace_sync_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(rec_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (rec_in),
      .pop_i   (pop),
      .dout_o  (trc_record),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (push && kind == HALT) state_d = DRAIN;
         DRAIN:   if (fifo_empty)           state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      inum_d  = inum_q;
      cycle_d = cycle_q;
      inst_d  = inst_q;
      drop_d  = drop_q;
      if (retire) inum_d = inum_q + CNT_ONE;
      if (state_q != DONE && cycle_q != '1) cycle_d = cycle_q + CNT_ONE;
      if (retire && inst_q != '1)           inst_d  = inst_q + CNT_ONE;
      if (drop && drop_q != '1)             drop_d  = drop_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         inum_q  <= '0;
         cycle_q <= '0;
         inst_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         inum_q  <= inum_d;
         cycle_q <= cycle_d;
         inst_q  <= inst_d;
         drop_q  <= drop_d;
      end
   end

   assign cycle_count = cycle_q;
   assign inst_count  = inst_q;
   assign drop_count  = drop_q;
   assign halted      = (state_q == DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - directed self-checking bench for retire_trace_buffer
module tb_retire_trace_buffer;
   import retire_trace_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ret_valid = 1'b0;
   logic [15:0] ret_pc = '0;
   logic [15:0] ret_inst = '0;
   logic        ret_reg_write = 1'b0;
   logic [2:0]  ret_write_reg = '0;
   logic [15:0] ret_write_data = '0;
   logic        ret_mem_read = 1'b0;
   logic        ret_mem_write = 1'b0;
   logic [15:0] ret_mem_addr = '0;
   logic [15:0] ret_mem_data = '0;
   logic        ret_halt = 1'b0;
   logic        ret_stall;
   logic        trc_valid;
   logic        trc_ready = 1'b0;
   rec_t        trc_record;
   logic [31:0] cycle_count, inst_count, drop_count;
   logic        halted;

   int checks = 0;
   int errors = 0;
   int exp_cyc = 0;
   bit exp_done = 1'b0;

   retire_trace_buffer #(
      .DATA_W(16), .REG_IDX_W(3), .DEPTH(8), .CNT_W(32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ret_valid      (ret_valid),
      .ret_pc         (ret_pc),
      .ret_inst       (ret_inst),
      .ret_reg_write  (ret_reg_write),
      .ret_write_reg  (ret_write_reg),
      .ret_write_data (ret_write_data),
      .ret_mem_read   (ret_mem_read),
      .ret_mem_write  (ret_mem_write),
      .ret_mem_addr   (ret_mem_addr),
      .ret_mem_data   (ret_mem_data),
      .ret_halt       (ret_halt),
      .ret_stall      (ret_stall),
      .trc_valid      (trc_valid),
      .trc_ready      (trc_ready),
      .trc_record     (trc_record),
      .cycle_count    (cycle_count),
      .inst_count     (inst_count),
      .drop_count     (drop_count),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!exp_done) exp_cyc++;
   endtask

   task automatic drv(input logic v, input logic rw, input logic mr, input logic mw,
                      input logic h, input logic [15:0] pc, input logic [15:0] addr);
      ret_valid      = v;
      ret_reg_write  = rw;
      ret_mem_read   = mr;
      ret_mem_write  = mw;
      ret_halt       = h;
      ret_pc         = pc;
      ret_inst       = pc ^ 16'h5A5A;
      ret_write_reg  = pc[2:0];
      ret_write_data = pc + 16'd1;
      ret_mem_addr   = addr;
      ret_mem_data   = 16'hBEEF;
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      trc_ready = 1'b0;
      drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      exp_cyc  = 0;
      exp_done = 1'b0;
   endtask

   initial begin
      reset_dut();
      chk("rst_trc_valid", trc_valid, 0);
      chk("rst_ret_stall", ret_stall, 0);
      chk("rst_halted", halted, 0);
      chk("rst_inst_count", inst_count, 0);
      chk("rst_cycle_count", cycle_count, 0);

      // 1: three REG records, sink always ready
      trc_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 0, 0, 0, 16'h0100 + 16'(i), 16'h0);
         tick();
         chk("t1_valid", trc_valid, 1);
         chk("t1_inum", trc_record.inum, i);
         chk("t1_kind", trc_record.kind, REG);
         chk("t1_pc", trc_record.pc, 16'h0100 + 16'(i));
         chk("t1_inst", trc_record.inst, (16'h0100 + 16'(i)) ^ 16'h5A5A);
      end
      drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      chk("t1_empty", trc_valid, 0);
      chk("t1_inst_count", inst_count, 3);
      chk("t1_cycle_count", cycle_count, exp_cyc);

      // 2: fill with sink stalled, ninth record dropped
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         drv(1, 1, 0, 0, 0, 16'h0200 + 16'(i), 16'h0);
         tick();
      end
      chk("t2_stall_full", ret_stall, 1);
      chk("t2_head_inum", trc_record.inum, 0);
      chk("t2_head_pc", trc_record.pc, 16'h0200);
      drv(1, 1, 0, 0, 0, 16'h0208, 16'h0);
      tick();
      chk("t2_drop_count", drop_count, 1);
      chk("t2_inst_count", inst_count, 8);
      chk("t2_head_held", trc_record.inum, 0);
      chk("t2_stall_still", ret_stall, 1);

      // 3: push and pop together at full
      trc_ready = 1'b1;
      drv(1, 1, 0, 0, 0, 16'h0209, 16'h0);
      #1;
      chk("t3_stall_released", ret_stall, 0);
      tick();
      chk("t3_head_after", trc_record.inum, 1);
      trc_ready = 1'b0;
      drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
      #1;
      chk("t3_still_full", ret_stall, 1);
      trc_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk("t3_drain_valid", trc_valid, 1);
         chk("t3_drain_inum", trc_record.inum, k);
         tick();
      end
      chk("t3_empty", trc_valid, 0);
      chk("t3_inst_count", inst_count, 9);
      chk("t3_cycle_count", cycle_count, exp_cyc);

      // 4: classification
      drv(1, 1, 0, 1, 0, 16'h0400, 16'h0010);
      tick();
      chk("t4_stu_kind", trc_record.kind, STU);
      chk("t4_stu_addr", trc_record.addr, 16'h0010);
      chk("t4_stu_mdata", trc_record.mdata, 16'hBEEF);
      chk("t4_stu_inum", trc_record.inum, 9);
      drv(1, 1, 1, 0, 0, 16'h0401, 16'h0020);
      tick();
      chk("t4_load_kind", trc_record.kind, LOAD);
      chk("t4_load_inum", trc_record.inum, 10);
      drv(1, 0, 0, 1, 0, 16'h0402, 16'h0030);
      tick();
      chk("t4_store_kind", trc_record.kind, STORE);
      chk("t4_store_inum", trc_record.inum, 11);
      drv(1, 1, 0, 0, 1, 16'h0403, 16'h0);
      tick();
      chk("t4_reg_over_halt", trc_record.kind, REG);
      chk("t4_reg_inum", trc_record.inum, 12);
      drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      chk("t4_empty", trc_valid, 0);
      chk("t4_inst_count", inst_count, 13);

      // 5: halt with two records ahead of it, then drain to DONE
      trc_ready = 1'b0;
      drv(1, 1, 0, 0, 0, 16'h0500, 16'h0);
      tick();
      drv(1, 1, 0, 0, 0, 16'h0501, 16'h0);
      tick();
      drv(1, 0, 0, 0, 1, 16'h0502, 16'h0);
      tick();
      drv(1, 1, 0, 0, 0, 16'h0503, 16'h0);
      tick();
      chk("t5_ignored_inst", inst_count, 16);
      chk("t5_ignored_drop", drop_count, 1);
      chk("t5_not_halted", halted, 0);
      trc_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("t5_drain_inum", trc_record.inum, 13 + k);
         chk("t5_drain_kind", trc_record.kind, (k == 2) ? HALT : REG);
         tick();
      end
      chk("t5_empty", trc_valid, 0);
      chk("t5_halted_early", halted, 0);
      tick();
      exp_done = 1'b1;
      chk("t5_halted", halted, 1);
      chk("t5_cycle_at_done", cycle_count, exp_cyc);
      tick();
      tick();
      chk("t5_cycle_frozen", cycle_count, exp_cyc);
      chk("t5_inst_frozen", inst_count, 16);
      chk("t5_halted_sticky", halted, 1);

      // 6: async reset while draining
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 0, 0, 0, 16'h0600 + 16'(i), 16'h0);
         tick();
      end
      drv(1, 0, 0, 0, 1, 16'h0603, 16'h0);
      tick();
      drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
      chk("t6_pre_valid", trc_valid, 1);
      chk("t6_pre_inst", inst_count, 4);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", trc_valid, 0);
      chk("t6_async_inst", inst_count, 0);
      chk("t6_async_cycle", cycle_count, 0);
      chk("t6_async_halted", halted, 0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      exp_cyc  = 0;
      exp_done = 1'b0;

      trc_ready = 1'b1;
      drv(1, 0, 0, 0, 0, 16'h0700, 16'h0);
      tick();
`ifdef RETIRE_TRACE_SKIP_NOP_EN
      chk("t6_nop_filtered", trc_valid, 0);
      chk("t6_nop_counted", inst_count, 1);
`else
      chk("t6_nop_valid", trc_valid, 1);
      chk("t6_nop_kind", trc_record.kind, NOP);
      chk("t6_nop_inum", trc_record.inum, 0);
`endif
      drv(1, 1, 0, 0, 0, 16'h0701, 16'h0);
      tick();
      chk("t6_reg_valid", trc_valid, 1);
      chk("t6_reg_inum", trc_record.inum, 1);
      chk("t6_reg_kind", trc_record.kind, REG);
      drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      chk("t6_empty", trc_valid, 0);
      chk("t6_inst_count", inst_count, 2);
      chk("t6_cycle_count", cycle_count, exp_cyc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
